// File: rtl/sqrt_sched_pkg.sv
// Shared types and the round-robin pick function for sqrt_rr_scheduler.
package sqrt_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESPOND,
    RELEASE
  } sched_state_t;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned MAX_REQ    = 16;
  localparam int unsigned MAX_PTR_W  = 4;
  localparam int unsigned IDX_W      = MAX_PTR_W + 1;

  // First set bit of valid at or above ptr, wrapping at n_req; one-hot result.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   valid,
    input logic [MAX_PTR_W-1:0] ptr,
    input int unsigned          n_req
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    logic [IDX_W-1:0]   idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + IDX_W'(k);
      if (idx >= IDX_W'(n_req)) begin
        idx = idx - IDX_W'(n_req);
      end
      if ((k < n_req) && !found && valid[idx[MAX_PTR_W-1:0]]) begin
        grant[idx[MAX_PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin selector: pending requests plus pointer in,
// one-hot grant and binary id out.
module rr_grant_picker
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] id_o
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [MAX_REQ-1:0] grant_full;

  assign grant_full = rr_pick(MAX_REQ'(valid_i), MAX_PTR_W'(ptr_i), N_REQ);
  assign grant_o    = grant_full[N_REQ-1:0];

  generate
    if (N_REQ < MAX_REQ) begin : g_hi
      logic unused_grant_hi;
      assign unused_grant_hi = |grant_full[MAX_REQ-1:N_REQ];
    end
  endgenerate

  always_comb begin
    id_o = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (grant_o[j]) begin
        id_o = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/sqrt_rr_scheduler.sv
// Round-robin sharing of one START/DONE/AVAILABLE sqrt unit among N_REQ requesters.
// Optional WAIT_DONE watchdog enabled by defining SQRT_SCHED_TIMEOUT_EN.
module sqrt_rr_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_accept,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic [DATA_W-1:0]       sq_in,
  output logic                    sq_start,
  input  logic [DATA_W-1:0]       sq_out,
  input  logic                    sq_done,
  input  logic                    sq_available,
  output logic                    busy
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  req_accept_q, req_accept_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] sq_in_q, sq_in_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              sq_start_q, sq_start_d;
  logic [DATA_W-1:0] req_ops [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ops
      assign req_ops[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_grant_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .id_o    (grant_id)
  );

`ifdef SQRT_SCHED_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        rsp_err_q, rsp_err_d;
  logic        timeout;

  assign timeout = (cnt_q == 16'(TIMEOUT_CYC - 1));
  assign rsp_err = rsp_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign rsp_err            = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    rr_ptr_d     = rr_ptr_q;
    sq_in_d      = sq_in_q;
    sq_start_d   = sq_start_q;
    req_accept_d = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
`ifdef SQRT_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid && sq_available) begin
          id_d         = grant_id;
          sq_in_d      = req_ops[grant_id];
          req_accept_d = grant;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        sq_start_d = 1'b1;
        state_d    = WAIT_DONE;
`ifdef SQRT_SCHED_TIMEOUT_EN
        cnt_d      = '0;
`endif
      end
      WAIT_DONE: begin
        if (sq_done) begin
          sq_start_d  = 1'b0;
          rsp_data_d  = sq_out;
          rsp_valid_d = N_REQ'(1) << id_q;
          state_d     = RESPOND;
`ifdef SQRT_SCHED_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (timeout) begin
          // Abort: the unit sees START fall and the requester gets an error result.
          sq_start_d  = 1'b0;
          rsp_data_d  = '0;
          rsp_valid_d = N_REQ'(1) << id_q;
          rsp_err_d   = 1'b1;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      RESPOND: begin
        state_d = RELEASE;
`ifdef SQRT_SCHED_TIMEOUT_EN
        rsp_err_d = 1'b0;
`endif
      end
      RELEASE: begin
        if (sq_available) begin
          rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      id_q         <= '0;
      rr_ptr_q     <= '0;
      sq_in_q      <= '0;
      sq_start_q   <= 1'b0;
      req_accept_q <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      rr_ptr_q     <= rr_ptr_d;
      sq_in_q      <= sq_in_d;
      sq_start_q   <= sq_start_d;
      req_accept_q <= req_accept_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign req_accept = req_accept_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign sq_in      = sq_in_q;
  assign sq_start   = sq_start_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Self-checking bench for sqrt_rr_scheduler with a behavioural sqrt unit and
// an accept/response scoreboard. Define SQRT_SCHED_TIMEOUT_EN for the watchdog case.
module tb_sqrt_rr_scheduler;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_accept;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic [DW-1:0]   sq_in;
  logic            sq_start;
  logic [DW-1:0]   sq_out = '0;
  logic            sq_done = 1'b0;
  logic            sq_available = 1'b1;
  logic            busy;

  sqrt_rr_scheduler #(
    .N_REQ       (NR),
    .DATA_W      (DW),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_accept   (req_accept),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .sq_in        (sq_in),
    .sq_start     (sq_start),
    .sq_out       (sq_out),
    .sq_done      (sq_done),
    .sq_available (sq_available),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] v;
    logic [DW-1:0] d;
    logic          e;
  } rsp_t;

  typedef struct {
    int            id;
    logic [DW-1:0] operand;
    logic [NR-1:0] exp_accept;
    logic [DW-1:0] exp_data;
  } vec_t;

  logic [NR-1:0] exp_acc[$];
  rsp_t          exp_rsp[$];
  int n_pass = 0;
  int n_total = 0;
  int acc_seen = 0;
  logic force_unavail = 1'b0;
  logic never_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] isqrt_q16(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    r = '0;
    while ((64'(r) + 64'd1) * (64'(r) + 64'd1) <= 64'(x)) r++;
    return r << 16;
  endfunction

  // Behavioural sqrt unit, driven on the falling edge.
  logic          m_busy = 1'b0;
  int            m_cnt = 0;
  logic [DW-1:0] m_res = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      m_busy = 1'b0;
      sq_done = 1'b0;
      sq_out = 32'hDEAD_BEEF;
      sq_available = !force_unavail;
    end else if (!m_busy) begin
      sq_done = 1'b0;
      sq_available = !force_unavail;
      if (sq_start && sq_available) begin
        m_busy = 1'b1;
        m_cnt = LAT;
        m_res = isqrt_q16(sq_in);
        sq_available = 1'b0;
      end
    end else if (!sq_start) begin
      m_busy = 1'b0;
      sq_done = 1'b0;
      sq_out = 32'hDEAD_BEEF;
      sq_available = !force_unavail;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && !never_done) begin
        sq_done = 1'b1;
        sq_out = m_res;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    rsp_t r;
    if (rstn) begin
      if (req_accept != '0) begin
        acc_seen++;
        if (exp_acc.size() == 0) check("unexpected_accept", 64'(req_accept), 64'd0);
        else check("accept", 64'(req_accept), 64'(exp_acc.pop_front()));
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        else begin
          r = exp_rsp.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(r.v));
          check("rsp_data", 64'(rsp_data), 64'(r.d));
          check("rsp_err", 64'(rsp_err), 64'(r.e));
        end
      end
    end
  end

  task automatic expect_op(input int id, input logic [DW-1:0] res, input logic err);
    rsp_t r;
    r.v = NR'(1) << id;
    r.d = res;
    r.e = err;
    exp_acc.push_back(NR'(1) << id);
    exp_rsp.push_back(r);
  endtask

  task automatic wait_accept_drop();
    for (int c = 0; c < 200 && req_valid != '0; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_accept;
    end
    check("accept_wait", 64'(req_valid), 64'd0);
    req_valid = '0;
  endtask

  task automatic drain();
    int pend;
    for (int c = 0; c < 400; c++) begin
      if (exp_acc.size() == 0 && exp_rsp.size() == 0 && !busy) break;
      @(negedge clk);
    end
    pend = exp_acc.size() + exp_rsp.size() + int'(busy);
    check("drain", 64'(pend), 64'd0);
    exp_acc.delete();
    exp_rsp.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic do_req(input int id, input logic [DW-1:0] op, input logic [DW-1:0] res);
    req_data[id*DW +: DW] = op;
    expect_op(id, res, 1'b0);
    req_valid = NR'(1) << id;
    wait_accept_drop();
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int bad;
    int base;
    int waitcyc;
    vecs[0] = '{1, 32'h0000_0010, 4'b0010, 32'h0004_0000};
    vecs[1] = '{0, 32'h0000_0001, 4'b0001, 32'h0001_0000};
    vecs[2] = '{3, 32'h0000_0019, 4'b1000, 32'h0005_0000};
    vecs[3] = '{2, 32'h0000_0100, 4'b0100, 32'h0010_0000};
    vecs[4] = '{1, 32'h0000_0000, 4'b0010, 32'h0000_0000};

    // Reset state, with requests pending that must not be granted.
    req_valid = '1;
    repeat (3) @(negedge clk);
    check("rst_req_accept", 64'(req_accept), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_sq_in", 64'(sq_in), 64'd0);
    check("rst_sq_start", 64'(sq_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Single requests from the vector table.
    for (int i = 0; i < 5; i++) begin
      req_data[vecs[i].id*DW +: DW] = vecs[i].operand;
      exp_acc.push_back(vecs[i].exp_accept);
      exp_rsp.push_back('{vecs[i].exp_accept, vecs[i].exp_data, 1'b0});
      req_valid = vecs[i].exp_accept;
      wait_accept_drop();
      drain();
    end

    // All four continuously requesting: rotation from pointer 0.
    reset_dut();
    req_data = {32'd16, 32'd9, 32'd4, 32'd1};
    for (int k = 0; k < 5; k++) expect_op(k % NR, 32'((k % NR) + 1) << 16, 1'b0);
    base = acc_seen;
    req_valid = '1;
    for (int c = 0; c < 400 && acc_seen < base + 5; c++) @(negedge clk);
    req_valid = '0;
    check("rotation_accepts", 64'(acc_seen - base), 64'd5);
    drain();

    // Unit not available: no grant, no START.
    force_unavail = 1'b1;
    repeat (2) @(negedge clk);
    req_data[0*DW +: DW] = 32'h0000_0040;
    expect_op(0, 32'h0008_0000, 1'b0);
    req_valid = 4'b0001;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_accept != '0 || sq_start) bad++;
    end
    check("unavail_no_grant", 64'(bad), 64'd0);
    force_unavail = 1'b0;
    wait_accept_drop();
    drain();

    // Reset while waiting for DONE; pointer must restart at 0.
    req_data[2*DW +: DW] = 32'h0000_0024;
    exp_acc.push_back(4'b0100);
    req_valid = 4'b0100;
    for (int c = 0; c < 100 && !sq_start; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_accept;
    end
    check("wait_done_reached", 64'(sq_start), 64'd1);
    #2;
    rstn = 1'b0;
    req_valid = '0;
    #1;
    check("arst_sq_start", 64'(sq_start), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_pulses", 64'({req_accept, rsp_valid}), 64'd0);
    exp_acc.delete();
    exp_rsp.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    req_data[0*DW +: DW] = 32'h0000_0009;
    req_data[2*DW +: DW] = 32'h0000_0024;
    expect_op(0, 32'h0003_0000, 1'b0);
    expect_op(2, 32'h0006_0000, 1'b0);
    req_valid = 4'b0101;
    wait_accept_drop();
    drain();

`ifdef SQRT_SCHED_TIMEOUT_EN
    // Unit never finishes: watchdog aborts after 8 WAIT_DONE cycles.
    never_done = 1'b1;
    req_data[1*DW +: DW] = 32'h0000_0010;
    expect_op(1, 32'h0, 1'b1);
    req_valid = 4'b0010;
    waitcyc = 0;
    for (int c = 0; c < 100 && rsp_valid == '0; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_accept;
      if (sq_start) waitcyc++;
    end
    check("timeout_wait_cycles", 64'(waitcyc), 64'd8);
    never_done = 1'b0;
    req_valid = '0;
    drain();
    do_req(3, 32'h0000_0031, 32'h0007_0000);
`else
    waitcyc = 0;
`endif

    // Request dropped one cycle after accept: still answered once.
    req_data[2*DW +: DW] = 32'h0000_0051;
    expect_op(2, 32'h0009_0000, 1'b0);
    req_valid = 4'b0100;
    for (int c = 0; c < 100 && req_accept == '0; c++) @(negedge clk);
    check("late_drop_accept", 64'(req_accept), 64'b0100);
    @(negedge clk);
    req_valid = '0;
    drain();

    do_req(1, 32'h0000_0010, 32'h0004_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
